regfile_mp: RTL and testbench

Parametrised multi-port register file with two write ports, an issue scoreboard and a registered debug readout. It is the datapath register store for the next processor core: two operand reads per cycle, writeback from two pipes, and busy tracking so decode can detect RAW hazards without a separate scoreboard block. It replaces the fixed 8×32 single-write store and its eight hard-wired observation outputs.

---
 rtl/regfile_mp_if.sv | 39 +++
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register-file port bundle: two read ports, two write ports, issue and debug.
// No latency of its own; carries no flow control because every port is accepted every cycle.
// master = the core pipeline driving the store, slave = the register file itself.
interface regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
);
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             busy1;
    logic             busy2;

    logic             we0;
    logic [AW-1:0]    wa0;
    logic [WIDTH-1:0] wd0;
    logic             we1;
    logic [AW-1:0]    wa1;
    logic [WIDTH-1:0] wd1;

    logic             iss_v;
    logic [AW-1:0]    iss_a;
    logic [DEPTH-1:0] busy_vec;

    logic [AW-1:0]    dbg_a;
    logic [WIDTH-1:0] dbg_d;

    modport master (
        output ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, iss_v, iss_a, dbg_a,
        input  rd1, rd2, busy1, busy2, busy_vec, dbg_d
    );

    modport slave (
        input  ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, iss_v, iss_a, dbg_a,
        output rd1, rd2, busy1, busy2, busy_vec, dbg_d
    );
endinterface

// File: rtl/regfile_mp.sv
// Dual-write register file with issue scoreboard and registered debug read.
// Write-to-read 1 cycle (0 with RF_BYPASS_EN), issue/clear 1 cycle, dbg_d 1 cycle.
// No backpressure: all ports accepted every cycle; RF_BYPASS_EN enables same-cycle write forwarding.
module regfile_mp #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1),
    parameter int               ZERO_REG  = 0
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [WIDTH-1:0] dbg_q;

    // An address maps to real storage only if in range and not the hard-wired zero register.
    function automatic logic readable(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [WIDTH-1:0] stored_rd(input logic [AW-1:0] a);
        return readable(a) ? mem[a] : '0;
    endfunction

    function automatic logic stored_busy(input logic [AW-1:0] a);
        return readable(a) ? busy[a] : 1'b0;
    endfunction

`ifdef RF_BYPASS_EN
    function automatic logic [WIDTH-1:0] fwd_rd(input logic [AW-1:0] a);
        logic [WIDTH-1:0] d;
        d = stored_rd(a);
        if (readable(a)) begin
            if (bus.we1 && bus.wa1 == a) begin
                d = bus.wd1;
            end else if (bus.we0 && bus.wa0 == a) begin
                d = bus.wd0;
            end
        end
        return d;
    endfunction

    // A same-cycle producer write hides busy unless a new producer issues to the same register.
    function automatic logic fwd_busy(input logic [AW-1:0] a);
        logic hit;
        logic iss;
        hit = (bus.we1 && bus.wa1 == a) || (bus.we0 && bus.wa0 == a);
        iss = bus.iss_v && bus.iss_a == a;
        return stored_busy(a) && !(hit && !iss);
    endfunction

    always_comb begin
        bus.rd1   = fwd_rd(bus.ra1);
        bus.rd2   = fwd_rd(bus.ra2);
        bus.busy1 = fwd_busy(bus.ra1);
        bus.busy2 = fwd_busy(bus.ra2);
    end
`else
    always_comb begin
        bus.rd1   = stored_rd(bus.ra1);
        bus.rd2   = stored_rd(bus.ra2);
        bus.busy1 = stored_busy(bus.ra1);
        bus.busy2 = stored_busy(bus.ra2);
    end
`endif

    assign bus.busy_vec = busy;
    assign bus.dbg_d    = dbg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
            busy  <= '0;
            dbg_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!((ZERO_REG != 0) && (i == 0))) begin
                    // Port 1 has priority on an address collision.
                    if (bus.we1 && bus.wa1 == AW'(i)) begin
                        mem[i] <= bus.wd1;
                    end else if (bus.we0 && bus.wa0 == AW'(i)) begin
                        mem[i] <= bus.wd0;
                    end
                    if (bus.iss_v && bus.iss_a == AW'(i)) begin
                        busy[i] <= 1'b1;
                    end else if ((bus.we1 && bus.wa1 == AW'(i)) ||
                                 (bus.we0 && bus.wa0 == AW'(i))) begin
                        busy[i] <= 1'b0;
                    end
                end
            end
            dbg_q <= stored_rd(bus.dbg_a);
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp: an 8-entry instance and a 6-entry zero-register instance.
module tb_regfile_mp;
    logic clk;
    logic rst;

    regfile_mp_if #(.WIDTH(32), .DEPTH(8)) if0 ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(6)) if1 ();

    regfile_mp #(.WIDTH(32), .DEPTH(8), .RESET_VAL(32'd1), .ZERO_REG(0))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    regfile_mp #(.WIDTH(32), .DEPTH(6), .RESET_VAL(32'd1), .ZERO_REG(1))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic        we0;
        logic [2:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [2:0]  wa1;
        logic [31:0] wd1;
        logic        iss_v;
        logic [2:0]  iss_a;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [2:0]  dbg_a;
        logic [31:0] x_rd1;
        logic [31:0] x_rd2;
        logic [7:0]  x_busy;
        logic [31:0] x_dbg;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(logic we0, logic [2:0] wa0, logic [31:0] wd0,
                                logic we1, logic [2:0] wa1, logic [31:0] wd1,
                                logic iss_v, logic [2:0] iss_a,
                                logic [2:0] ra1, logic [2:0] ra2, logic [2:0] dbg_a,
                                logic [31:0] x_rd1, logic [31:0] x_rd2,
                                logic [7:0] x_busy, logic [31:0] x_dbg);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.iss_v = iss_v; v.iss_a = iss_a;
        v.ra1 = ra1; v.ra2 = ra2; v.dbg_a = dbg_a;
        v.x_rd1 = x_rd1; v.x_rd2 = x_rd2; v.x_busy = x_busy; v.x_dbg = x_dbg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle0();
        if0.we0 = 0; if0.we1 = 0; if0.iss_v = 0;
    endtask

    task automatic idle1();
        if1.we0 = 0; if1.we1 = 0; if1.iss_v = 0;
    endtask

    initial begin
        // Inputs quiet before anything else happens.
        rst = 0;
        if0.ra1 = 0; if0.ra2 = 4; if0.dbg_a = 0; if0.iss_a = 0;
        if0.wa0 = 0; if0.wd0 = 0; if0.wa1 = 0; if0.wd1 = 0;
        if1.ra1 = 0; if1.ra2 = 7; if1.dbg_a = 0; if1.iss_a = 0;
        if1.wa0 = 0; if1.wd0 = 0; if1.wa1 = 0; if1.wd1 = 0;
        idle0(); idle1();

        tbl[0] = mk(1,3,32'hAAAA, 1,3,32'h5555, 0,0, 3,0,3, 32'h5555,32'h1,   8'h00, 32'h1);
        tbl[1] = mk(0,0,0,        0,0,0,        0,0, 3,3,3, 32'h5555,32'h5555,8'h00, 32'h5555);
        tbl[2] = mk(0,0,0,        0,0,0,        1,5, 5,3,5, 32'h1,   32'h5555,8'h20, 32'h1);
        tbl[3] = mk(1,5,32'h77,   0,0,0,        1,5, 5,3,5, 32'h77,  32'h5555,8'h20, 32'h1);
        tbl[4] = mk(0,0,0,        1,5,32'h88,   0,0, 5,3,5, 32'h88,  32'h5555,8'h00, 32'h77);
        tbl[5] = mk(1,1,32'h11,   1,6,32'h66,   1,2, 1,6,1, 32'h11,  32'h66,  8'h04, 32'h1);
        tbl[6] = mk(1,2,32'h22,   0,0,0,        1,7, 2,7,6, 32'h22,  32'h1,   8'h80, 32'h66);
        tbl[7] = mk(0,0,0,        1,7,32'h70,   1,7, 2,7,7, 32'h22,  32'h70,  8'h80, 32'h1);
        tbl[8] = mk(1,7,32'h71,   0,0,0,        0,0, 7,0,2, 32'h71,  32'h1,   8'h00, 32'h22);

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1;
        #1;
        chk("rst rd1", if0.rd1, 32'h1);
        chk("rst rd2", if0.rd2, 32'h1);
        chk("rst busy_vec", 32'(if0.busy_vec), 32'h0);
        chk("rst dbg_d", if0.dbg_d, 32'h0);
        chk("rst zero-reg rd1", if1.rd1, 32'h0);
        chk("rst out-of-range rd2", if1.rd2, 32'h0);

        // State holds while reset is high even if a write is presented.
        if0.we0 = 1; if0.wa0 = 3; if0.wd0 = 32'hDEAD; if0.ra1 = 3;
        repeat (2) @(posedge clk);
        #1 chk("rst hold rd1", if0.rd1, 32'h1);
        @(negedge clk);
        idle0();
        rst = 0;

        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if0.we0 = tbl[k].we0; if0.wa0 = tbl[k].wa0; if0.wd0 = tbl[k].wd0;
            if0.we1 = tbl[k].we1; if0.wa1 = tbl[k].wa1; if0.wd1 = tbl[k].wd1;
            if0.iss_v = tbl[k].iss_v; if0.iss_a = tbl[k].iss_a;
            if0.ra1 = tbl[k].ra1; if0.ra2 = tbl[k].ra2; if0.dbg_a = tbl[k].dbg_a;
            @(posedge clk);
            #1 idle0();
            #1;
            chk($sformatf("v%0d rd1", k), if0.rd1, tbl[k].x_rd1);
            chk($sformatf("v%0d rd2", k), if0.rd2, tbl[k].x_rd2);
            chk($sformatf("v%0d busy_vec", k), 32'(if0.busy_vec), 32'(tbl[k].x_busy));
            chk($sformatf("v%0d busy1", k), 32'(if0.busy1), 32'(tbl[k].x_busy[tbl[k].ra1]));
            chk($sformatf("v%0d dbg_d", k), if0.dbg_d, tbl[k].x_dbg);
        end

        // Forwarding: reg 2 holds 0x22; issue it, then write it while reading it.
        @(negedge clk);
        if0.iss_v = 1; if0.iss_a = 2; if0.ra1 = 2;
        @(negedge clk);
        idle0();
        chk("byp pre busy1", 32'(if0.busy1), 32'h1);
        if0.we0 = 1; if0.wa0 = 2; if0.wd0 = 32'h1234;
        #1;
`ifdef RF_BYPASS_EN
        chk("byp same-cycle rd1", if0.rd1, 32'h1234);
        chk("byp same-cycle busy1", 32'(if0.busy1), 32'h0);
`else
        chk("byp same-cycle rd1", if0.rd1, 32'h22);
        chk("byp same-cycle busy1", 32'(if0.busy1), 32'h1);
`endif
        @(posedge clk);
        #1 idle0();
        #1;
        chk("byp next rd1", if0.rd1, 32'h1234);
        chk("byp next busy1", 32'(if0.busy1), 32'h0);

        // Zero register and out-of-range on the 6-entry instance.
        @(negedge clk);
        if1.we0 = 1; if1.wa0 = 0; if1.wd0 = 32'hFFFF;
        if1.we1 = 1; if1.wa1 = 7; if1.wd1 = 32'hFFFF;
        if1.iss_v = 1; if1.iss_a = 0;
        if1.ra1 = 0; if1.ra2 = 7; if1.dbg_a = 0;
        @(posedge clk);
        #1 idle1();
        #1;
        chk("z rd1 reg0", if1.rd1, 32'h0);
        chk("z rd2 reg7", if1.rd2, 32'h0);
        chk("z busy_vec iss0", 32'(if1.busy_vec), 32'h0);
        chk("z busy1 reg0", 32'(if1.busy1), 32'h0);
        chk("z dbg_d reg0", if1.dbg_d, 32'h0);
        @(negedge clk);
        if1.iss_v = 1; if1.iss_a = 7; if1.dbg_a = 7;
        @(posedge clk);
        #1 idle1();
        #1;
        chk("z busy_vec iss7", 32'(if1.busy_vec), 32'h0);
        chk("z busy2 reg7", 32'(if1.busy2), 32'h0);
        chk("z dbg_d reg7", if1.dbg_d, 32'h0);
        // Highest valid entry still behaves normally.
        @(negedge clk);
        if1.we0 = 1; if1.wa0 = 5; if1.wd0 = 32'hABCD;
        if1.ra1 = 5; if1.ra2 = 3; if1.dbg_a = 5;
        @(posedge clk);
        #1 idle1();
        if1.iss_v = 1; if1.iss_a = 5;
        #1;
        chk("z rd1 reg5", if1.rd1, 32'hABCD);
        chk("z rd2 reg3", if1.rd2, 32'h1);
        @(posedge clk);
        #1 idle1();
        #1;
        chk("z busy_vec iss5", 32'(if1.busy_vec), 32'h20);
        chk("z dbg_d reg5", if1.dbg_d, 32'hABCD);

        // Reset arriving alongside a write: the write is lost.
        @(negedge clk);
        if0.we1 = 1; if0.wa1 = 4; if0.wd1 = 32'hBEEF;
        rst = 1;
        @(posedge clk);
        #1 idle0();
        @(negedge clk);
        rst = 0;
        if0.ra1 = 4; if0.ra2 = 3; if0.dbg_a = 4;
        #1;
        chk("mid-rst rd1 reg4", if0.rd1, 32'h1);
        chk("mid-rst rd2 reg3", if0.rd2, 32'h1);
        chk("mid-rst busy_vec", 32'(if0.busy_vec), 32'h0);
        @(posedge clk);
        #2 chk("mid-rst dbg_d", if0.dbg_d, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
